// File: rtl/kgp_alu_pkg.sv
// kgp_alu_pkg: op codes, flag bit positions and FSM states shared by the ALU pipeline
package kgp_alu_pkg;
  localparam logic [3:0] OP_XOR  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_COMP = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_SHLL = 4'd5;
  localparam logic [3:0] OP_SHRL = 4'd6;
  localparam logic [3:0] OP_SHRA = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_S = 2;
  localparam int FLG_V = 3;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_HOLD} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one multiplier bit per cycle, WIDTH cycles from start to done
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic             hi_nonzero
);
  localparam int CW = $clog2(WIDTH);
  logic             busy;
  logic [CW-1:0]    cnt;
  logic [2*WIDTH-1:0] acc, mcand, nxt;
  logic [WIDTH-1:0] mplier;
  // bit 0 is folded into the start edge, so done marks the cycle computing the last bit
  assign nxt        = acc + (mplier[0] ? mcand : '0);
  assign done       = busy && cnt == CW'(WIDTH - 2);
  assign lo         = nxt[WIDTH-1:0];
  assign hi_nonzero = |nxt[2*WIDTH-1:WIDTH];
  // accumulate one partial product per cycle while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier <= b >> 1;
    end else if (busy) begin
      acc    <= nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      busy   <= !done;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshake, iterative multiply, flush and sticky overflow
module alu_pipe
  import kgp_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);
  localparam int SW = $clog2(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] bb, res, sra;
  logic [WIDTH:0]   sum;
  logic [3:0]       flg;
  logic [SW-1:0]    sh;
  logic             big, arith, sub, accept, start, consume;
  logic             mul_done, mul_hnz;
  logic [WIDTH-1:0] mul_lo;
  logic [TAG_W-1:0] mtag;
  assign in_ready = rst_n && (state == ST_IDLE || (state == ST_HOLD && out_ready));
  assign accept   = in_valid && in_ready && !flush;
  assign start    = accept && in_op == OP_MUL;
  assign consume  = out_valid && out_ready && !flush;
  // single-cycle datapath; shift amounts of WIDTH or more saturate
  always_comb begin
    sub   = in_op == OP_SUB;
    arith = in_op == OP_ADD || sub;
    bb    = sub ? ~in_b : in_b;
    sum   = {1'b0, in_a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
    big   = (in_b >> SW) != '0;
    sh    = in_b[SW-1:0];
    sra   = $signed(in_a) >>> sh;
    res   = in_op == OP_XOR  ? in_a ^ in_b :
            in_op == OP_AND  ? in_a & in_b :
            in_op == OP_COMP ? ~in_b :
            arith            ? sum[WIDTH-1:0] :
            in_op == OP_SHLL ? (big ? '0 : in_a << sh) :
            in_op == OP_SHRL ? (big ? '0 : in_a >> sh) :
            in_op == OP_SHRA ? (big ? {WIDTH{in_a[WIDTH-1]}} : sra) : '0;
    flg        = '0;
    flg[FLG_C] = arith && sum[WIDTH];
    flg[FLG_V] = arith && (in_a[WIDTH-1] ^ bb[WIDTH-1] ^ sum[WIDTH-1] ^ sum[WIDTH]);
    flg[FLG_Z] = in_op < OP_MUL && res == '0;
    flg[FLG_S] = in_op < OP_MUL && res[WIDTH-1];
  end
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rst_n(rst_n), .abort(flush), .start(start), .a(in_a), .b(in_b),
    .done(mul_done), .lo(mul_lo), .hi_nonzero(mul_hnz)
  );
  // control FSM and output register; flush beats accept and consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_tag   <= '0;
      out_flags <= '0;
      mtag      <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else if (state == ST_MUL) begin
      if (mul_done) begin
        state     <= ST_HOLD;
        out_valid <= 1'b1;
        out_res   <= mul_lo;
        out_tag   <= mtag;
        out_flags <= {mul_hnz, mul_lo[WIDTH-1], mul_lo == '0, 1'b0};
      end
    end else if (start) begin
      state     <= ST_MUL;
      out_valid <= 1'b0;
      mtag      <= in_tag;
    end else if (accept) begin
      state     <= ST_HOLD;
      out_valid <= 1'b1;
      out_res   <= res;
      out_tag   <= in_tag;
      out_flags <= flg;
    end else if (consume) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end
  end
  // sticky overflow: set on consume of a V result, set beats clear, frozen during flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_sticky <= 1'b0;
    else if (!flush) ovf_sticky <= (consume && out_flags[FLG_V]) ? 1'b1 : clr_sticky ? 1'b0 : ovf_sticky;
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors with hand-computed results for alu_pipe at WIDTH=32
module tb_alu_pipe;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_ready;
  logic [3:0]  in_op = '0, out_flags;
  logic [31:0] in_a = '0, in_b = '0, out_res;
  logic [4:0]  in_tag = '0, out_tag;
  logic        out_valid, out_ready = 1'b0, ovf_sticky, clr_sticky = 1'b0;
  int          n_vec = 0, n_bad = 0;
  alu_pipe #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag), .out_flags(out_flags),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // offer one single-cycle op, check it one cycle later while held, then consume it
  task automatic op1(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] tg, input logic [31:0] er, input logic [3:0] ef);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tg; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check(tag, {in_ready, out_valid, out_tag, out_flags, out_res}, {1'b0, 1'b1, tg, ef, er});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask
  // start a multiply and return in cycle 10 after the accept
  task automatic mul_to_cycle10(input logic [4:0] tg);
    in_valid = 1'b1; in_op = 4'd8; in_a = 32'h1234; in_b = 32'h5678; in_tag = tg;
    step();
    in_valid = 1'b0;
    repeat (9) step();
  endtask
  initial begin
    int rise, rdy_seen, bad;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", {in_ready, out_valid, out_tag, out_flags, out_res, ovf_sticky}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdy", in_ready, 1);
    step();
    op1("add_ovf",  4'd3, 32'h7FFFFFFF, 32'h1,        5'd1, 32'h80000000, 4'b1100);
    check("sticky_set", ovf_sticky, 1);
    clr_sticky = 1'b1; step(); clr_sticky = 1'b0;
    check("sticky_clr", ovf_sticky, 0);
    op1("add_carry", 4'd3, 32'hFFFFFFFF, 32'h1,       5'd2, 32'h0,        4'b0011);
    op1("sub_neg",   4'd4, 32'd5,        32'd7,       5'd3, 32'hFFFFFFFE, 4'b0100);
    op1("sub_zero",  4'd4, 32'd7,        32'd7,       5'd4, 32'h0,        4'b0011);
    op1("shra4",     4'd7, 32'h80000000, 32'd4,       5'd5, 32'hF8000000, 4'b0100);
    op1("shll32",    4'd5, 32'h1,        32'd32,      5'd6, 32'h0,        4'b0010);
    op1("shra40",    4'd7, 32'h80000000, 32'd40,      5'd7, 32'hFFFFFFFF, 4'b0100);
    op1("shrl31",    4'd6, 32'h80000000, 32'd31,      5'd8, 32'h1,        4'b0000);
    op1("xor",       4'd0, 32'h0000F0F0, 32'h00000FF0, 5'd9, 32'h0000FF00, 4'b0000);
    op1("and",       4'd1, 32'hFF00FF00, 32'h0FF00FF0, 5'd10, 32'h0F000F00, 4'b0000);
    op1("comp",      4'd2, 32'h12345678, 32'h0,       5'd11, 32'hFFFFFFFF, 4'b0100);
    op1("illegal",   4'd9, 32'h0,        32'h0,       5'd12, 32'h0,        4'b0000);
    check("sticky_quiet", ovf_sticky, 0);
    in_valid = 1'b1; in_op = 4'd8; in_a = 32'h10000; in_b = 32'h10000; in_tag = 5'h13;
    step();
    in_valid = 1'b0;
    rise = -1; rdy_seen = 0;
    for (int k = 1; k <= 40 && rise < 0; k++) begin
      @(negedge clk);
      if (in_ready) rdy_seen = 1;
      if (out_valid) rise = k;
      if (rise < 0) step();
    end
    check("mul_lat", rise, 32);
    check("mul_rdy", rdy_seen, 0);
    check("mul_out", {out_valid, out_tag, out_flags, out_res}, {1'b1, 5'h13, 4'b1010, 32'h0});
    check("mul_sticky_pre", ovf_sticky, 0);
    step();
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("mul_sticky", ovf_sticky, 1);
    clr_sticky = 1'b1; step(); clr_sticky = 1'b0;
    check("mul_sticky_clr", ovf_sticky, 0);
    in_valid = 1'b1; in_op = 4'd3; in_a = 32'd1; in_b = 32'd1; in_tag = 5'd1;
    step();
    in_a = 32'd2; in_b = 32'd2; in_tag = 5'd2;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (!out_valid || out_res !== 32'd2 || out_tag !== 5'd1 || in_ready) bad++;
      step();
    end
    check("bp_hold", bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_r1", {out_valid, out_tag, out_res}, {1'b1, 5'd1, 32'd2});
    step();
    in_a = 32'd3; in_b = 32'd3; in_tag = 5'd3;
    @(negedge clk);
    check("bp_r2", {out_valid, out_tag, out_res}, {1'b1, 5'd2, 32'd4});
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_r3", {out_valid, out_tag, out_res}, {1'b1, 5'd3, 32'd6});
    step();
    out_ready = 1'b0;
    check("bp_empty", out_valid, 0);
    in_valid = 1'b1; in_op = 4'd3; in_a = 32'h7FFFFFFF; in_b = 32'h1; in_tag = 5'd4;
    step();
    in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b1;
    step();
    out_ready = 1'b0; clr_sticky = 1'b0;
    check("sticky_set_wins", ovf_sticky, 1);
    mul_to_cycle10(5'd20);
    flush = 1'b1;
    in_valid = 1'b1; in_op = 4'd0; in_a = 32'hA5; in_b = 32'h0F; in_tag = 5'd7;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle", {out_valid, in_ready, ovf_sticky}, {1'b0, 1'b1, 1'b1});
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_xor", {out_valid, out_tag, out_flags, out_res}, {1'b1, 5'd7, 4'b0000, 32'hAA});
    out_ready = 1'b1; step(); out_ready = 1'b0;
    rise = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) rise = 1;
    end
    check("flush_no_mul", rise, 0);
    step();
    mul_to_cycle10(5'd21);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mul", {in_ready, out_valid, out_tag, out_flags, out_res, ovf_sticky}, '0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_rdy", in_ready, 1);
    rise = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) rise = 1;
    end
    check("rst_no_mul", rise, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
